cpu_prog_loader: RTL and testbench

Serial program loader for the 8-bit CPU's instruction memory: the inbound counterpart to the board-level register/LED outputs. It receives a framed program image over a UART RX pin, writes it byte-by-byte into instruction memory, and holds the CPU in reset while a load is in progress. It sits in the FPGA top level beside the CPU, driving the instruction-memory write port and the CPU's reset input.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/uart_rx_byte.sv | 147 ++++++++++++++
 rtl/cpu_prog_loader.sv | 187 ++++++++++++++++++
 tb/tb_cpu_prog_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the program loader and its UART receiver.
//   SYNC_BYTE   - frame start marker
//   IMEM_AW     - instruction-memory address width
//   DATA_W      - byte width on the serial link and the memory port
//   ldr_state_e - frame FSM states
//   rx_state_e  - receiver bit-timing states
//   frame_len() - maps the LEN byte to a byte count (0 means 256)
package cpu_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         IMEM_AW   = 8;
  localparam int         DATA_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } ldr_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_BITS  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver.
//   clk, rst   - system clock, asynchronous active-high reset
//   rx         - serial input, idle high, asynchronous to clk
//   rx_byte    - received byte, valid while rx_valid is high
//   rx_valid   - one-cycle pulse: a byte with a good stop bit arrived
//   rx_ferr    - one-cycle pulse: stop bit sampled low, byte dropped
//   rx_state   - debug view of the receiver state
// A falling edge in idle starts a byte; the start bit is re-checked at
// mid-bit and a glitch returns to idle silently. Data bits are sampled LSB
// first at mid-bit. After the stop-bit sample the receiver returns to idle
// straight away, so a start bit right after the stop bit is not missed.
module uart_rx_byte
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_byte,
  output logic              rx_valid,
  output logic              rx_ferr,
  output rx_state_e         rx_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e         state_q, state_d;
  logic [1:0]        sync_q;
  logic              prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  logic rx_s;
  logic fall;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  // Reset to 1 so the idle line does not look like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      prev_q <= rx_s;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (cnt_q == HALF_CNT) state_d = rx_s ? RX_IDLE : RX_BITS;
      RX_BITS:  if (cnt_q == LAST_CNT && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (cnt_q == LAST_CNT) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
      end
      RX_START: begin
        // After the half-bit wait every later sample lands mid-bit.
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          bit_d = 3'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BITS: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;
  assign rx_state = state_q;

endmodule

// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader: loads a framed program image from a UART into the
// CPU instruction memory and holds the CPU in reset while loading.
//   clk, rst       - system clock, asynchronous active-high reset
//   uart_rx        - serial input (8N1, idle high)
//   imem_we        - one-cycle write strobe to instruction memory
//   imem_addr      - write address (stable while imem_we is high)
//   imem_wdata     - write data (stable while imem_we is high)
//   cpu_hold       - high while a load is open or after a failed load
//   load_done      - sticky: last frame passed its checksum
//   load_err       - sticky: last frame failed (checksum, framing, timeout)
//   dbg_state      - debug view of the frame FSM
//   dbg_rx_state   - debug view of the receiver
// Frame: A5, LEN (0 = 256), LEN data bytes, CSUM = sum of data mod 256.
// Handshake: the receiver presents rx_byte together with a one-cycle
// rx_valid pulse; there is no back-pressure, the loader must take every
// byte in the cycle it is offered. All loader outputs are registered and
// react on the edge after the rx_valid cycle.
module cpu_prog_loader
  import cpu_pkg::*;
#(
  parameter int CLK_HZ       = 125000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [DATA_W-1:0]  imem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output ldr_state_e         dbg_state,
  output rx_state_e          dbg_rx_state
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W         = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  logic [DATA_W-1:0] rx_byte;
  logic              rx_valid;
  logic              rx_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_state (dbg_rx_state)
  );

  ldr_state_e         state_q, state_d;
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IMEM_AW-1:0] cnt_q, cnt_d;     // next write address, wraps at 256
  logic [DATA_W-1:0]  acc_q, acc_d;     // running checksum
  logic [8:0]         rem_q, rem_d;     // data bytes still expected
  logic [TO_W-1:0]    to_q, to_d;       // cycles since the last byte

  logic in_frame;
  logic timeout;
  logic abort;

  assign in_frame = (state_q != IDLE);
  // A byte arriving in the very cycle the counter expires wins.
  assign timeout  = in_frame && !rx_valid && (to_q == TO_LAST);
  assign abort    = in_frame && (rx_ferr || timeout);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        IDLE:    if (rx_byte == SYNC_BYTE) state_d = LEN;
        LEN:     state_d = DATA;
        DATA:    if (rem_q == 9'd1) state_d = CSUM;
        CSUM:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath logic (next values of the registered outputs)
  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;

    if (!in_frame || rx_valid) to_d = '0;
    else                       to_d = to_q + 1'b1;

    if (abort) begin
      // Bytes already written stay in memory; the CPU stays held.
      err_d = 1'b1;
    end else if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_byte == SYNC_BYTE) begin
            hold_d = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
            cnt_d  = '0;
            acc_d  = '0;
          end
        end
        LEN: rem_d = frame_len(rx_byte);
        DATA: begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = rx_byte;
          cnt_d   = cnt_q + 1'b1;
          acc_d   = acc_q + rx_byte;
          rem_d   = rem_q - 9'd1;
        end
        CSUM: begin
          if (rx_byte == acc_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      to_q    <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      to_q    <= to_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Testbench for cpu_prog_loader with CLKS_PER_BIT = 16 and a short
// timeout (64 bit periods) to keep the run compact.
module tb_cpu_prog_loader;
  import cpu_pkg::*;

  localparam int CPB     = 16;
  localparam int BAUD_TB = 115200;
  localparam int CLK_TB  = BAUD_TB * CPB;
  localparam int TO_BITS = 64;
  localparam int TO_CYC  = TO_BITS * CPB;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  ldr_state_e dbg_state;
  rx_state_e  dbg_rx_state;

  always #5 clk = ~clk;

  cpu_prog_loader #(
    .CLK_HZ       (CLK_TB),
    .BAUD         (BAUD_TB),
    .TIMEOUT_BITS (TO_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .dbg_state    (dbg_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_mis = 0;
  logic [15:0] exp_q[$];     // expected {addr, data} writes
  logic [15:0] act_q[$];     // observed writes, appended by the monitor
  int          act_base = 0; // first unchecked entry of act_q
  logic        m_hold, m_done, m_err;
  logic [7:0]  fr[$];

  always @(negedge clk) begin
    if (imem_we) act_q.push_back({imem_addr, imem_wdata});
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got no end of test, required end before 95000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Walks one byte stream: skips to the first SYNC, reads the length,
  // lists the writes the data bytes produce and judges the checksum.
  function automatic void model_frame(input logic [7:0] s[$]);
    int         i;
    int         n;
    logic [7:0] sum;
    i = 0;
    while (i < s.size() && s[i] != SYNC_BYTE) i++;
    if (i + 1 >= s.size()) return;
    m_hold = 1'b1;
    m_done = 1'b0;
    m_err  = 1'b0;
    n   = (s[i+1] == 8'd0) ? 256 : int'(s[i+1]);
    i   = i + 2;
    sum = 8'd0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({8'(k), s[i+k]});
      sum = sum + s[i+k];
    end
    if (s[i+n] == sum) begin
      m_done = 1'b1;
      m_hold = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, " load_done"}, load_done, m_done);
    check({tag, " load_err"}, load_err, m_err);
    check({tag, " cpu_hold"}, cpu_hold, m_hold);
  endtask

  task automatic check_writes(input string tag);
    int n_act;
    n_act = act_q.size() - act_base;
    check({tag, " write_count"}, n_act, exp_q.size());
    for (int k = 0; k < n_act && k < exp_q.size(); k++)
      check($sformatf("%s write%0d", tag, k), act_q[act_base+k], exp_q[k]);
    act_base = act_q.size();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  // Sends fr; while no SYNC has been seen the loader must stay idle, and
  // the SYNC byte itself must raise cpu_hold and clear the sticky flags.
  task automatic send_frame(input string tag, input bit watch_sync, input int max_gap);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < fr.size(); k++) begin
      send_byte(fr[k]);
      if (watch_sync && !seen) begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (fr[k] == SYNC_BYTE) begin
          seen = 1'b1;
          check({tag, " hold_after_sync"}, cpu_hold, 1);
          check({tag, " done_cleared"}, load_done, 0);
          check({tag, " err_cleared"}, load_err, 0);
        end else begin
          check({tag, " idle_on_noise"}, dbg_state, IDLE);
        end
      end
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         nb;
    logic [7:0] b [8];
    logic       done;
    logic       err;
    logic       hold;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [7:0] sum;
    logic [7:0] cs;
    int         n;
    int         waited;

    vt[0].nb = 6; vt[0].b = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66, 8'h00, 8'h00};
    vt[0].done = 1'b1; vt[0].err = 1'b0; vt[0].hold = 1'b0;
    vt[1].nb = 5; vt[1].b = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31, 8'h00, 8'h00, 8'h00};
    vt[1].done = 1'b0; vt[1].err = 1'b1; vt[1].hold = 1'b1;
    vt[2].nb = 4; vt[2].b = '{8'hA5, 8'h01, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[2].done = 1'b1; vt[2].err = 1'b0; vt[2].hold = 1'b0;
    vt[3].nb = 8; vt[3].b = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4A};
    vt[3].done = 1'b1; vt[3].err = 1'b0; vt[3].hold = 1'b0;

    // ---- reset state ----
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_hold = 1'b0; m_done = 1'b0; m_err = 1'b0;
    check("rst imem_we", imem_we, 0);
    check("rst imem_addr", imem_addr, 0);
    check("rst imem_wdata", imem_wdata, 0);
    check_flags("rst");
    check("rst fsm_state", dbg_state, IDLE);
    check("rst rx_state", dbg_rx_state, RX_IDLE);
    repeat (10) @(posedge clk);

    // ---- table-driven frames ----
    for (int v = 0; v < 4; v++) begin
      fr.delete();
      for (int k = 0; k < vt[v].nb; k++) fr.push_back(vt[v].b[k]);
      model_frame(fr);
      send_frame($sformatf("vec%0d", v), 1'b1, 0);
      settle();
      check($sformatf("vec%0d load_done", v), load_done, vt[v].done);
      check($sformatf("vec%0d load_err", v), load_err, vt[v].err);
      check($sformatf("vec%0d cpu_hold", v), cpu_hold, vt[v].hold);
      check_writes($sformatf("vec%0d", v));
      repeat (20) @(posedge clk);
    end

    // ---- LEN = 0: 256 bytes, value i at index i ----
    fr.delete();
    fr.push_back(SYNC_BYTE);
    fr.push_back(8'h00);
    for (int i = 0; i < 256; i++) fr.push_back(8'(i));
    fr.push_back(8'h80);
    model_frame(fr);
    send_frame("len256", 1'b0, 0);
    settle();
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_flags("len256");
    check_writes("len256");

    // ---- stop bit low on the second data byte ----
    send_byte(SYNC_BYTE);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    settle();
    exp_q.push_back({8'h00, 8'h11});
    m_hold = 1'b1; m_done = 1'b0; m_err = 1'b1;
    check_flags("ferr");
    check("ferr fsm_state", dbg_state, IDLE);
    check_writes("ferr");
    repeat (40) @(posedge clk);

    // ---- stall after LEN = 4 and one data byte ----
    send_byte(SYNC_BYTE);
    send_byte(8'h04);
    send_byte(8'h55);
    repeat (TO_CYC - 200) @(posedge clk);
    @(negedge clk);
    check("timeout early load_err", load_err, 0);
    check("timeout early cpu_hold", cpu_hold, 1);
    waited = 0;
    while (!load_err && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    exp_q.push_back({8'h00, 8'h55});
    check_flags("timeout");
    check("timeout fsm_state", dbg_state, IDLE);
    check_writes("timeout");
    repeat (20) @(posedge clk);

    // ---- reset in the middle of DATA ----
    send_byte(SYNC_BYTE);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    settle();
    exp_q.push_back({8'h00, 8'h01});
    exp_q.push_back({8'h01, 8'h02});
    check_writes("pre_rst");
    check("pre_rst cpu_hold", cpu_hold, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    m_hold = 1'b0; m_done = 1'b0; m_err = 1'b0;
    check("midrst imem_we", imem_we, 0);
    check("midrst imem_addr", imem_addr, 0);
    check("midrst imem_wdata", imem_wdata, 0);
    check_flags("midrst");
    check("midrst fsm_state", dbg_state, IDLE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    fr.delete();
    fr = '{8'hA5, 8'h02, 8'h33, 8'h44, 8'h77};
    model_frame(fr);
    send_frame("post_rst", 1'b1, 0);
    settle();
    check_flags("post_rst");
    check_writes("post_rst");

    // ---- randomized frames with random gaps (0 = back-to-back) ----
    for (int r = 0; r < 10; r++) begin
      fr.delete();
      if ($urandom_range(0, 1) == 1) begin
        cs = 8'($urandom_range(0, 255));
        if (cs == SYNC_BYTE) cs = 8'h00;
        fr.push_back(cs);
      end
      n = $urandom_range(1, 6);
      fr.push_back(SYNC_BYTE);
      fr.push_back(8'(n));
      sum = 8'd0;
      for (int k = 0; k < n; k++) begin
        cs = 8'($urandom_range(0, 255));
        fr.push_back(cs);
        sum = sum + cs;
      end
      if ($urandom_range(0, 2) == 0) sum = sum + 8'($urandom_range(1, 255));
      fr.push_back(sum);
      model_frame(fr);
      send_frame($sformatf("rand%0d", r), 1'b0, 20);
      settle();
      check_flags($sformatf("rand%0d", r));
      check($sformatf("rand%0d fsm_state", r), dbg_state, IDLE);
      check_writes($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
